// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue between the host register decode and the SD data master.
// Define SD_BD_ERR_EN to build the sticky err_wr/err_rd drop flags.
module sd_bd_queue #(
    parameter  int DW     = 32,
    parameter  int BD_NUM = 4,
    localparam int WPB    = 64 / DW,
    localparam int DEPTH  = BD_NUM * WPB,
    localparam int CW     = $clog2(BD_NUM) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we_m,
    input  logic [DW-1:0] dat_in_m,
    output logic [CW-1:0] free_bd,
    input  logic          re_s,
    output logic          ack_o_s,
    output logic [DW-1:0] dat_out_s,
    output logic          bd_avail,
    input  logic          a_cmp,
    output logic          err_wr,
    output logic          err_rd
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = $clog2(WPB);

    logic [DW-1:0]  mem [DEPTH];

    logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [WCW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [CW-1:0]  free_q, free_d, rdy_q, rdy_d;
    logic           last_a_q, last_a_d, cmp_edge_q, cmp_edge_d;
    logic           ack_q, ack_d;
    logic [DW-1:0]  dout_q, dout_d;

    logic           wr_acc, rd_acc, wr_done, rd_done, cmp_inc;
    logic [CW:0]    lim;

    always_comb begin
        wr_acc  = we_m && (free_q != '0);
        rd_acc  = re_s && (rdy_q != '0);
        wr_done = wr_acc && (wcnt_q == WCW'(WPB - 1));
        rd_done = rd_acc && (rcnt_q == WCW'(WPB - 1));
        // A slot still being filled cannot be released by a completion.
        lim     = (CW+1)'(BD_NUM) - {1'b0, rdy_q} - (CW+1)'(wcnt_q != '0);
        cmp_inc = cmp_edge_q && ({1'b0, free_q} < lim);

        wp_d       = wr_acc ? wp_q + AW'(1) : wp_q;
        wcnt_d     = wr_acc ? wcnt_q + WCW'(1) : wcnt_q;
        rp_d       = rd_acc ? rp_q + AW'(1) : rp_q;
        rcnt_d     = rd_acc ? rcnt_q + WCW'(1) : rcnt_q;
        free_d     = free_q + CW'(cmp_inc) - CW'(wr_done);
        rdy_d      = rdy_q + CW'(wr_done) - CW'(rd_done);
        ack_d      = rd_acc;
        dout_d     = rd_acc ? mem[rp_q] : dout_q;
        last_a_d   = a_cmp;
        // Registering the edge makes completions land one cycle after detection.
        cmp_edge_d = a_cmp && !last_a_q;

        if (clr) begin
            wp_d       = '0;
            rp_d       = '0;
            wcnt_d     = '0;
            rcnt_d     = '0;
            rdy_d      = '0;
            free_d     = CW'(BD_NUM);
            last_a_d   = 1'b0;
            cmp_edge_d = 1'b0;
            ack_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            rdy_q      <= '0;
            free_q     <= CW'(BD_NUM);
            last_a_q   <= 1'b0;
            cmp_edge_q <= 1'b0;
            ack_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            rdy_q      <= rdy_d;
            free_q     <= free_d;
            last_a_q   <= last_a_d;
            cmp_edge_q <= cmp_edge_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
        end
    end

    // Storage is never reset; clr only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr)
            mem[wp_q] <= dat_in_m;
    end

    assign free_bd   = free_q;
    assign ack_o_s   = ack_q;
    assign dat_out_s = dout_q;
    assign bd_avail  = (rdy_q != '0);

`ifdef SD_BD_ERR_EN
    logic err_wr_q, err_wr_d, err_rd_q, err_rd_d;

    always_comb begin
        err_wr_d = err_wr_q || (we_m && !wr_acc);
        err_rd_d = err_rd_q || (re_s && !rd_acc) || (cmp_edge_q && !cmp_inc);
        if (clr) begin
            err_wr_d = 1'b0;
            err_rd_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_wr_q <= 1'b0;
            err_rd_q <= 1'b0;
        end else begin
            err_wr_q <= err_wr_d;
            err_rd_q <= err_rd_d;
        end
    end

    assign err_wr = err_wr_q;
    assign err_rd = err_rd_q;
`else
    assign err_wr = 1'b0;
    assign err_rd = 1'b0;
`endif

endmodule

// File: tb/tb_sd_bd_queue.sv
// Scoreboard bench for sd_bd_queue: DUT a is DW=16/BD_NUM=4, DUT b is DW=32/BD_NUM=2.
module tb_sd_bd_queue;
`ifdef SD_BD_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_clr = 0, a_we = 0, a_re = 0, a_cmp = 0;
    logic [15:0] a_din = '0, a_dout;
    logic [2:0]  a_free;
    logic        a_ack, a_avail, a_ewr, a_erd;

    logic        b_clr = 0, b_we = 0, b_re = 0, b_cmp = 0;
    logic [31:0] b_din = '0, b_dout;
    logic [1:0]  b_free;
    logic        b_ack, b_avail, b_ewr, b_erd;

    int checks = 0;
    int failures = 0;
    logic [15:0] qa[$];
    logic [31:0] qb[$];

    sd_bd_queue #(.DW(16), .BD_NUM(4)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .we_m(a_we), .dat_in_m(a_din),
        .free_bd(a_free), .re_s(a_re), .ack_o_s(a_ack), .dat_out_s(a_dout),
        .bd_avail(a_avail), .a_cmp(a_cmp), .err_wr(a_ewr), .err_rd(a_erd)
    );

    sd_bd_queue #(.DW(32), .BD_NUM(2)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .we_m(b_we), .dat_in_m(b_din),
        .free_bd(b_free), .re_s(b_re), .ack_o_s(b_ack), .dat_out_s(b_dout),
        .bd_avail(b_avail), .a_cmp(b_cmp), .err_wr(b_ewr), .err_rd(b_erd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Read monitors: every ack pops the oldest expected word.
    always @(negedge clk) begin
        if (!rst && a_ack) begin
            if (qa.size() == 0) chk("a_unexpected_ack", 32'(a_dout), 32'hdead);
            else chk("a_read_data", 32'(a_dout), 32'(qa.pop_front()));
        end
        if (!rst && b_ack) begin
            if (qb.size() == 0) chk("b_unexpected_ack", b_dout, 32'hdeadbeef);
            else chk("b_read_data", b_dout, qb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wa(input logic [15:0] d);
        a_we = 1; a_din = d; tick(); a_we = 0;
    endtask

    task automatic ra(input logic [15:0] e);
        qa.push_back(e); a_re = 1; tick(); a_re = 0;
    endtask

    task automatic pa();
        a_cmp = 1; tick(); a_cmp = 0; tick();
    endtask

    task automatic aclr();
        a_clr = 1; tick(); a_clr = 0;
    endtask

    task automatic wdesc(input logic [15:0] base);
        for (int i = 0; i < 4; i++) wa(base + 16'(i));
    endtask

    task automatic rdesc(input logic [15:0] base);
        for (int i = 0; i < 4; i++) ra(base + 16'(i));
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        tick();
        chk("rst_free_a", 32'(a_free), 32'd4);
        chk("rst_free_b", 32'(b_free), 32'd2);
        chk("rst_avail", 32'(a_avail), 32'd0);
        chk("rst_ack", 32'(a_ack), 32'd0);
        chk("rst_dout", 32'(a_dout), 32'd0);
        chk("rst_err", {30'd0, a_ewr, a_erd}, 32'd0);

        // Empty read and completion with every slot free are both dropped.
        a_re = 1; tick(); a_re = 0;
        chk("empty_read_ack", 32'(a_ack), 32'd0);
        chk("empty_read_err", 32'(a_erd), 32'(ERR_EN));
        aclr();
        chk("clr_err", 32'(a_erd), 32'd0);
        pa();
        chk("cmp_full_free", 32'(a_free), 32'd4);
        chk("cmp_full_err", 32'(a_erd), 32'(ERR_EN));
        aclr();

        // Basic descriptor round trip.
        wa(16'h1111); wa(16'h2222); wa(16'h3333);
        chk("partial_free", 32'(a_free), 32'd4);
        chk("partial_avail", 32'(a_avail), 32'd0);
        wa(16'h4444);
        chk("desc_free", 32'(a_free), 32'd3);
        chk("desc_avail", 32'(a_avail), 32'd1);
        ra(16'h1111); ra(16'h2222); ra(16'h3333); ra(16'h4444);
        chk("drained_avail", 32'(a_avail), 32'd0);
        chk("drained_free", 32'(a_free), 32'd3);

        wdesc(16'h2000); rdesc(16'h2000);
        chk("two_out_free", 32'(a_free), 32'd2);

        // Registered completion edge coincides with the final word of a descriptor.
        wa(16'h3000); wa(16'h3001);
        a_cmp = 1;
        wa(16'h3002);
        wa(16'h3003);
        chk("simul_free", 32'(a_free), 32'd2);
        chk("simul_avail", 32'(a_avail), 32'd1);
        a_cmp = 0; tick();
        chk("simul_free_after", 32'(a_free), 32'd2);
        rdesc(16'h3000);

        // Completion latency: visible one edge after the edge that samples it.
        a_cmp = 1; tick();
        chk("cmp_lat_first_edge", 32'(a_free), 32'd2);
        a_cmp = 0; tick();
        chk("cmp_lat_second_edge", 32'(a_free), 32'd3);
        pa();
        chk("cmp_to_full", 32'(a_free), 32'd4);

        // Nine descriptors through four slots wrap both pointers.
        for (int k = 0; k < 9; k++) begin
            wdesc(16'h5000 + 16'(k * 16));
            rdesc(16'h5000 + 16'(k * 16));
            pa();
        end
        chk("wrap_free", 32'(a_free), 32'd4);
        chk("wrap_avail", 32'(a_avail), 32'd0);

        // Flush mid-descriptor discards the partial words.
        wa(16'h6000); wa(16'h6001); wa(16'h6002);
        aclr();
        chk("clr_free", 32'(a_free), 32'd4);
        chk("clr_avail", 32'(a_avail), 32'd0);
        chk("clr_errs", {30'd0, a_ewr, a_erd}, 32'd0);
        wdesc(16'h7000);
        chk("post_clr_free", 32'(a_free), 32'd3);
        rdesc(16'h7000);

        // 32-bit bus, two slots: fill, drop one, drain, then a long a_cmp pulse.
        for (int i = 0; i < 4; i++) begin
            b_we = 1; b_din = 32'ha000_0000 + 32'(i); tick(); b_we = 0;
            if (i == 1) chk("b_free_one", 32'(b_free), 32'd1);
        end
        chk("b_free_zero", 32'(b_free), 32'd0);
        chk("b_avail", 32'(b_avail), 32'd1);
        b_we = 1; b_din = 32'hbad0_bad0; tick(); b_we = 0;
        chk("b_drop_free", 32'(b_free), 32'd0);
        chk("b_err_wr", 32'(b_ewr), 32'(ERR_EN));
        for (int i = 0; i < 4; i++) begin
            qb.push_back(32'ha000_0000 + 32'(i));
            b_re = 1; tick(); b_re = 0;
        end
        chk("b_drained_avail", 32'(b_avail), 32'd0);
        b_cmp = 1; tick(); tick(); tick(); b_cmp = 0; tick();
        chk("b_hold_cmp_free", 32'(b_free), 32'd1);
        chk("b_err_rd", 32'(b_erd), 32'd0);

        tick(); tick();
        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
